// File: rtl/dyn_output_gen_pkg.sv
// Shared output-stage definitions: FSM state encoding and default timing
// parameters for the dynamic safety output generator and its checker.
package dyn_output_gen_pkg;

  // Generator state encoding; visible on state_o.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Default switch pulse shape (short/long phase lengths in cycles).
  localparam int unsigned DEF_SHORT_LEN = 1;
  localparam int unsigned DEF_LONG_LEN  = 15;

  // Default maximum gap between compare strobes while running.
  localparam int unsigned DEF_WDOG_LEN  = 64;

  // Default counter width; holds max(DEF_LONG_LEN, DEF_WDOG_LEN).
  localparam int unsigned DEF_CNT_W     = 7;

endpackage

// File: rtl/dyn_output_gen_cmp_watchdog.sv
// Compare watchdog: counts cycles since the last cmp_valid strobe while the
// generator is running and flags a timeout when the gap reaches WDOG_LEN.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   run        1 while the generator is in HIGH or LOW
//   clr        synchronous clear (generator leaving the running states)
//   cmpValid   compare-complete strobe; restarts the count
//   timeout_c  combinational: this edge is the WDOG_LEN-th without a strobe
module cmp_watchdog #(
  parameter int unsigned WDOG_LEN = 64,
  parameter int unsigned CNT_W    = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  input  logic cmpValid,
  output logic timeout_c
);

  logic [CNT_W-1:0] wdCnt;

  // Timeout fires on the edge that would take the count past WDOG_LEN-1.
  assign timeout_c = run && !cmpValid && (wdCnt == CNT_W'(WDOG_LEN - 1));

  // Gap counter; held at zero outside the running states, saturates at timeout.
  always_ff @(posedge clk) begin
    if (rst || clr || !run || cmpValid) begin
      wdCnt <= '0;
    end else if (!timeout_c) begin
      wdCnt <= wdCnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dyn_output_gen.sv
// Per-channel dynamic safety output generator. While compare results agree it
// produces a relay square wave (complementary between channels) and an
// asymmetric switch pulse train; on a mismatch or a compare watchdog timeout
// it freezes both outputs low and latches a sticky fault.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   enable       level; 1 = run, 0 = return to IDLE
//   cmp_valid    single-cycle compare-complete strobe
//   cmp_equal    compare result, qualified by cmp_valid
//   relay_ctrl   registered relay square wave
//   switch_ctrl  registered switch pulse train
//   fault        sticky fault flag, cleared only by rst
//   state_o      current FSM state
module dyn_output_gen
  import dyn_output_gen_pkg::*;
#(
  parameter bit          POLARITY  = 1'b0,
  parameter int unsigned SHORT_LEN = DEF_SHORT_LEN,
  parameter int unsigned LONG_LEN  = DEF_LONG_LEN,
  parameter int unsigned WDOG_LEN  = DEF_WDOG_LEN,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       cmp_valid,
  input  logic       cmp_equal,
  output logic       relay_ctrl,
  output logic       switch_ctrl,
  output logic       fault,
  output logic [1:0] state_o
);

  // Channel 2 swaps the phase lengths: long high / short low.
  localparam int unsigned H_LEN = POLARITY ? LONG_LEN : SHORT_LEN;
  localparam int unsigned L_LEN = POLARITY ? SHORT_LEN : LONG_LEN;

  state_t           state;
  logic [CNT_W-1:0] phCnt;
  logic             running;
  logic             timeout_c;
  logic             faultCond_c;
  logic             wdClr_c;

  assign running     = (state == ST_HIGH) || (state == ST_LOW);
  assign faultCond_c = running && ((cmp_valid && !cmp_equal) || timeout_c);
  assign wdClr_c     = running && (faultCond_c || !enable);
  assign state_o     = state;

  cmp_watchdog #(
    .WDOG_LEN (WDOG_LEN),
    .CNT_W    (CNT_W)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .run       (running),
    .clr       (wdClr_c),
    .cmpValid  (cmp_valid),
    .timeout_c (timeout_c)
  );

  // Generator FSM with registered outputs and phase counter.
  // Per-edge priority: rst > fault condition > enable low > phase end > count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      relay_ctrl  <= 1'b0;
      switch_ctrl <= 1'b0;
      fault       <= 1'b0;
      phCnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state       <= ST_HIGH;
            switch_ctrl <= 1'b1;
            relay_ctrl  <= POLARITY;
            phCnt       <= CNT_W'(H_LEN - 1);
          end else begin
            switch_ctrl <= 1'b0;
            relay_ctrl  <= 1'b0;
            phCnt       <= '0;
          end
        end

        ST_HIGH, ST_LOW: begin
          if (faultCond_c) begin
            state       <= ST_FAULT;
            switch_ctrl <= 1'b0;
            relay_ctrl  <= 1'b0;
            fault       <= 1'b1;
            phCnt       <= '0;
          end else if (!enable) begin
            state       <= ST_IDLE;
            switch_ctrl <= 1'b0;
            relay_ctrl  <= 1'b0;
            phCnt       <= '0;
          end else if (phCnt == '0) begin
            if (state == ST_HIGH) begin
              state       <= ST_LOW;
              switch_ctrl <= 1'b0;
              phCnt       <= CNT_W'(L_LEN - 1);
            end else begin
              // Relay toggles once per full pulse period, at the start of HIGH.
              state       <= ST_HIGH;
              switch_ctrl <= 1'b1;
              relay_ctrl  <= ~relay_ctrl;
              phCnt       <= CNT_W'(H_LEN - 1);
            end
          end else begin
            phCnt <= phCnt - CNT_W'(1);
          end
        end

        default: begin
          // FAULT is absorbing; only rst leaves it.
          state       <= ST_FAULT;
          switch_ctrl <= 1'b0;
          relay_ctrl  <= 1'b0;
          fault       <= 1'b1;
          phCnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dyn_output_gen.sv
// Directed bench for dyn_output_gen: a channel-1 and a channel-2 instance share
// clk/rst/enable/cmp inputs. Inputs change and outputs are sampled 1 time unit
// after each rising edge.
module tb_dyn_output_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       cmpValid;
  logic       cmpEqual;
  logic       relay1, switch1, fault1;
  logic       relay2, switch2, fault2;
  logic [1:0] state1, state2;

  int nTests = 0;
  int nFail  = 0;

  dyn_output_gen #(.POLARITY(1'b0)) u_ch1 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cmp_valid   (cmpValid),
    .cmp_equal   (cmpEqual),
    .relay_ctrl  (relay1),
    .switch_ctrl (switch1),
    .fault       (fault1),
    .state_o     (state1)
  );

  dyn_output_gen #(.POLARITY(1'b1)) u_ch2 (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cmp_valid   (cmpValid),
    .cmp_equal   (cmpEqual),
    .relay_ctrl  (relay2),
    .switch_ctrl (switch2),
    .fault       (fault2),
    .state_o     (state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    enable   = 1'b1;
    cmpValid = 1'b0;
    cmpEqual = 1'b0;

    // T1: reset held 3 cycles with enable high.
    repeat (3) tick();
    chk("t1_relay1",  32'(relay1),  0);
    chk("t1_switch1", 32'(switch1), 0);
    chk("t1_fault1",  32'(fault1),  0);
    chk("t1_state1",  32'(state1),  0);
    chk("t1_relay2",  32'(relay2),  0);
    chk("t1_switch2", 32'(switch2), 0);
    chk("t1_fault2",  32'(fault2),  0);
    chk("t1_state2",  32'(state2),  0);

    // T2/T3: both channels run; strobes with equal=1 every 10 cycles.
    // Edge k=1 enters HIGH. ch1: high 1 / low 15, ch2: high 15 / low 1.
    rst = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      cmpValid = (k % 10 == 0);
      cmpEqual = 1'b1;
      tick();
      cmpValid = 1'b0;
      chk($sformatf("t2_sw1_k%0d", k), 32'(switch1), 32'(((k - 1) % 16) == 0));
      chk($sformatf("t2_rl1_k%0d", k), 32'(relay1),  32'(((k - 1) / 16) % 2));
      chk($sformatf("t3_sw2_k%0d", k), 32'(switch2), 32'(((k - 1) % 16) < 15));
      chk($sformatf("t3_xor_k%0d", k), 32'(relay1 ^ relay2), 1);
    end

    // T4: mismatch on ch1's LOW->HIGH phase-end edge -> FAULT, no toggle.
    cmpValid = 1'b1;
    cmpEqual = 1'b0;
    tick();
    chk("t4_state1", 32'(state1), 3);
    chk("t4_fault1", 32'(fault1), 1);
    chk("t4_relay1", 32'(relay1), 0);
    chk("t4_sw1",    32'(switch1), 0);
    chk("t4_state2", 32'(state2), 3);
    chk("t4_fault2", 32'(fault2), 1);
    chk("t4_out2",   32'({relay2, switch2}), 0);
    // FAULT absorbs enable changes and compare strobes for 100 cycles.
    for (int k = 0; k < 100; k++) begin
      enable   = k[0];
      cmpValid = 1'b1;
      cmpEqual = k[1];
      tick();
      chk($sformatf("t4_hold1_k%0d", k), 32'({state1, fault1, relay1, switch1}), 32'b11100);
      chk($sformatf("t4_hold2_k%0d", k), 32'({state2, fault2, relay2, switch2}), 32'b11100);
    end

    // rst clears the sticky fault.
    cmpValid = 1'b0;
    enable   = 1'b1;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_rst_fault1", 32'(fault1), 0);
    chk("t4_rst_state1", 32'(state1), 0);
    chk("t4_rst_fault2", 32'(fault2), 0);

    // T5a: last strobe at edge 10 -> FAULT exactly at edge 74.
    for (int k = 1; k <= 74; k++) begin
      cmpValid = (k == 10);
      cmpEqual = 1'b1;
      tick();
      cmpValid = 1'b0;
      if (k >= 72) begin
        chk($sformatf("t5a_fault1_k%0d", k), 32'(fault1), 32'(k == 74));
        chk($sformatf("t5a_fault2_k%0d", k), 32'(fault2), 32'(k == 74));
      end
    end
    chk("t5a_state1", 32'(state1), 3);

    // T5b: strobe at edge 73 (63 after edge 10) keeps running; next timeout at 137.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 138; k++) begin
      cmpValid = (k == 10) || (k == 73);
      cmpEqual = 1'b1;
      tick();
      cmpValid = 1'b0;
      if (k == 73 || k == 74 || k == 75 || k >= 135)
        chk($sformatf("t5b_fault1_k%0d", k), 32'(fault1), 32'(k >= 137));
    end

    // T6: stop in ch2 HIGH, mismatch in IDLE ignored, restart.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    chk("t6_pre_state2", 32'(state2), 1);
    chk("t6_pre_state1", 32'(state1), 2);
    enable = 1'b0;
    tick();
    chk("t6_stop1", 32'({state1, relay1, switch1}), 0);
    chk("t6_stop2", 32'({state2, relay2, switch2}), 0);
    cmpValid = 1'b1;
    cmpEqual = 1'b0;
    tick();
    cmpValid = 1'b0;
    chk("t6_idle_mm1", 32'({state1, fault1}), 0);
    chk("t6_idle_mm2", 32'({state2, fault2}), 0);
    enable = 1'b1;
    tick();
    chk("t6_re_sw1",    32'(switch1), 1);
    chk("t6_re_rl1",    32'(relay1),  0);
    chk("t6_re_state1", 32'(state1),  1);
    chk("t6_re_sw2",    32'(switch2), 1);
    chk("t6_re_rl2",    32'(relay2),  1);
    tick();
    chk("t6_next_sw1", 32'(switch1), 0);
    chk("t6_next_sw2", 32'(switch2), 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
